// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and widths.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StStop   = 3'd3,
    StParity = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Host-side bus of the UART receiver: received byte, status flags and acknowledge.
// UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_receiver_if;
  import uart_pkg::*;

  logic                   rdy_clr;
  logic [UART_DATA_W-1:0] data;
  logic                   rdy;
  logic                   frame_err;
  logic                   overrun;
  logic                   busy;
`ifdef UART_RX_PARITY_EN
  logic                   parity_err;

  modport master (input rdy_clr, output data, rdy, frame_err, overrun, busy, parity_err);
  modport slave  (output rdy_clr, input data, rdy, frame_err, overrun, busy, parity_err);
`else
  modport master (input rdy_clr, output data, rdy, frame_err, overrun, busy);
  modport slave  (output rdy_clr, input data, rdy, frame_err, overrun, busy);
`endif

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to ResetVal.
module uart_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q, sync_d;

  // Shift the async input through the two stages.
  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  // Synchronizer flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {2{ResetVal}};
    else         sync_q <= sync_d;
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 16x-oversampled 8N1 recovery with sticky rdy/overrun and frame_err pulse.
// Defining UART_RX_PARITY_EN adds an even-parity bit between data and stop, and parity_err.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic            clk_50mhz,
  input  logic            rst_n,
  input  logic            rx,
  input  logic            clken,
  uart_receiver_if.master bus
);

  localparam int unsigned SampleW = $clog2(OVERSAMPLE);
  localparam logic [SampleW-1:0] SampleMid  = SampleW'(OVERSAMPLE / 2 - 1);
  localparam logic [SampleW-1:0] SampleLast = SampleW'(OVERSAMPLE - 1);

  logic                   rx_s;
  uart_state_e            state_q, state_d;
  logic [SampleW-1:0]     sample_q, sample_d;
  logic [2:0]             bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   rdy_q, rdy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                   parity_err_q, parity_err_d;
`endif

  uart_sync2 #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i (clk_50mhz),
    .rst_ni(rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // Next-state: handshake every clock, frame FSM only on clken ticks.
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rdy_d       = rdy_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif

    if (bus.rdy_clr) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (clken && !rx_s) begin
          state_d  = StStart;
          sample_d = '0;
        end
      end
      StStart: begin
        if (clken) begin
          if (rx_s) begin
            state_d = StIdle;  // glitch, not a real start bit
          end else if (sample_q == SampleMid) begin
            state_d  = StData;
            sample_d = '0;
            bit_d    = 3'd0;
          end else begin
            sample_d = sample_q + SampleW'(1);
          end
        end
      end
      StData: begin
        if (clken) begin
          if (sample_q == SampleLast) begin
            shift_d[bit_q] = rx_s;
            sample_d       = '0;
            bit_d          = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end else begin
            sample_d = sample_q + SampleW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (clken) begin
          if (sample_q == SampleLast) begin
            parity_err_d = rx_s ^ (^shift_q);
            sample_d     = '0;
            state_d      = StStop;
          end else begin
            sample_d = sample_q + SampleW'(1);
          end
        end
      end
`endif
      StStop: begin
        if (clken) begin
          if (sample_q == SampleLast) begin
            if (rx_s) begin
              data_d = shift_q;
              rdy_d  = 1'b1;
              // A simultaneous acknowledge consumes the old byte, so no overrun.
              if (rdy_q && !bus.rdy_clr) overrun_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
            state_d  = StIdle;
            sample_d = '0;
          end else begin
            sample_d = sample_q + SampleW'(1);
          end
        end
      end
      default: begin
        state_d  = StIdle;
        sample_d = '0;
        bit_d    = 3'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sample_q     <= '0;
      bit_q        <= 3'd0;
      shift_q      <= '0;
      data_q       <= '0;
      rdy_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      rdy_q        <= rdy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.data      = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver (honours UART_RX_PARITY_EN).
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
  localparam int StopTick   = 168;
  localparam int FrameTicks = 176;
`else
  localparam int StopTick   = 152;
  localparam int FrameTicks = 160;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic clken = 1'b0;
  int   checks = 0;
  int   errors = 0;
  // Observed status vector: {data, rdy, frame_err, overrun, busy}.
  logic [11:0] obs;

  uart_receiver_if bus ();

  uart_receiver #(
    .OVERSAMPLE(16)
  ) dut (
    .clk_50mhz(clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .clken    (clken),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  assign obs = {bus.data, bus.rdy, bus.frame_err, bus.overrun, bus.busy};

  // Line level at tick t of a frame (tick 0 = first low tick of the start bit).
  function automatic logic wire_bit(input logic [7:0] d, input logic stop_b,
                                    input logic par_flip, input int t);
    int slot;
    slot = t / 16;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
`ifdef UART_RX_PARITY_EN
    if (slot == 9) return (^d) ^ par_flip;
`endif
    return stop_b;
  endfunction

  // One oversample tick; rx has 3 clocks to settle through the synchronizer first.
  task automatic tick(input logic clr);
    repeat (3) @(negedge clk);
    clken       = 1'b1;
    bus.rdy_clr = clr;
    @(negedge clk);
    clken       = 1'b0;
    bus.rdy_clr = 1'b0;
  endtask

  task automatic drive(input logic [7:0] d, input logic stop_b, input logic par_flip,
                       input int from, input int to);
    for (int t = from; t <= to; t++) begin
      rx = wire_bit(d, stop_b, par_flip, t);
      tick(1'b0);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.rdy_clr = 1'b1;
    @(negedge clk);
    bus.rdy_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", obs, 12'h000);
    end
    rst_n = 1'b1;
    repeat (4) tick(1'b0);
  endtask

  task automatic test_frame_a5();
    drive(8'hA5, 1'b1, 1'b0, 0, StopTick - 1);
    checks++;
    if (obs !== {8'h00, 4'b0001}) begin
      errors++;
      $display("FAIL a5_before_stop: got %h want %h", obs, {8'h00, 4'b0001});
    end
    drive(8'hA5, 1'b1, 1'b0, StopTick, StopTick);
    checks++;
    if (obs !== {8'hA5, 4'b1000}) begin
      errors++;
      $display("FAIL a5_at_stop: got %h want %h", obs, {8'hA5, 4'b1000});
    end
    drive(8'hA5, 1'b1, 1'b0, StopTick + 1, FrameTicks - 1);
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (4) tick(1'b0);
    checks++;
    if (obs !== {8'hA5, 4'b1001}) begin
      errors++;
      $display("FAIL glitch_busy: got %h want %h", obs, {8'hA5, 4'b1001});
    end
    rx = 1'b1;
    tick(1'b0);
    checks++;
    if (obs !== {8'hA5, 4'b1000}) begin
      errors++;
      $display("FAIL glitch_idle: got %h want %h", obs, {8'hA5, 4'b1000});
    end
    repeat (4) tick(1'b0);
  endtask

  task automatic test_frame_err();
    pulse_clr();
    checks++;
    if (obs !== {8'hA5, 4'b0000}) begin
      errors++;
      $display("FAIL ferr_clr: got %h want %h", obs, {8'hA5, 4'b0000});
    end
    drive(8'h3C, 1'b0, 1'b0, 0, StopTick);
    checks++;
    if (obs !== {8'hA5, 4'b0100}) begin
      errors++;
      $display("FAIL ferr_pulse: got %h want %h", obs, {8'hA5, 4'b0100});
    end
    @(negedge clk);
    checks++;
    if (obs !== {8'hA5, 4'b0000}) begin
      errors++;
      $display("FAIL ferr_one_cycle: got %h want %h", obs, {8'hA5, 4'b0000});
    end
    rx = 1'b1;
    repeat (4) tick(1'b0);
  endtask

  task automatic test_overrun();
    drive(8'h11, 1'b1, 1'b0, 0, FrameTicks - 1);
    checks++;
    if (obs !== {8'h11, 4'b1000}) begin
      errors++;
      $display("FAIL ovr_first: got %h want %h", obs, {8'h11, 4'b1000});
    end
    drive(8'h22, 1'b1, 1'b0, 0, StopTick);
    checks++;
    if (obs !== {8'h22, 4'b1010}) begin
      errors++;
      $display("FAIL ovr_second: got %h want %h", obs, {8'h22, 4'b1010});
    end
    drive(8'h22, 1'b1, 1'b0, StopTick + 1, FrameTicks - 1);
    pulse_clr();
    checks++;
    if (obs !== {8'h22, 4'b0000}) begin
      errors++;
      $display("FAIL ovr_clear: got %h want %h", obs, {8'h22, 4'b0000});
    end
  endtask

  task automatic test_clr_collision();
    drive(8'h33, 1'b1, 1'b0, 0, FrameTicks - 1);
    checks++;
    if (obs !== {8'h33, 4'b1000}) begin
      errors++;
      $display("FAIL coll_first: got %h want %h", obs, {8'h33, 4'b1000});
    end
    drive(8'h44, 1'b1, 1'b0, 0, StopTick - 1);
    rx = wire_bit(8'h44, 1'b1, 1'b0, StopTick);
    tick(1'b1);
    checks++;
    if (obs !== {8'h44, 4'b1000}) begin
      errors++;
      $display("FAIL coll_set_wins: got %h want %h", obs, {8'h44, 4'b1000});
    end
    drive(8'h44, 1'b1, 1'b0, StopTick + 1, FrameTicks - 1);
  endtask

  task automatic test_reset_midframe();
    drive(8'hC3, 1'b1, 1'b0, 0, 59);
    checks++;
    if (obs !== {8'h44, 4'b1001}) begin
      errors++;
      $display("FAIL rst_mid_busy: got %h want %h", obs, {8'h44, 4'b1001});
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL rst_mid_values: got %h want %h", obs, 12'h000);
    end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(1'b0);
    drive(8'h5A, 1'b1, 1'b0, 0, FrameTicks - 1);
    checks++;
    if (obs !== {8'h5A, 4'b1000}) begin
      errors++;
      $display("FAIL rst_mid_5a: got %h want %h", obs, {8'h5A, 4'b1000});
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    pulse_clr();
    drive(8'h07, 1'b1, 1'b1, 0, 152);
    checks++;
    if ({bus.parity_err, bus.busy} !== 2'b11) begin
      errors++;
      $display("FAIL par_pulse: got %b want %b", {bus.parity_err, bus.busy}, 2'b11);
    end
    @(negedge clk);
    checks++;
    if (bus.parity_err !== 1'b0) begin
      errors++;
      $display("FAIL par_one_cycle: got %b want 0", bus.parity_err);
    end
    drive(8'h07, 1'b1, 1'b1, 153, StopTick);
    checks++;
    if (obs !== {8'h07, 4'b1000}) begin
      errors++;
      $display("FAIL par_data: got %h want %h", obs, {8'h07, 4'b1000});
    end
    drive(8'h07, 1'b1, 1'b1, StopTick + 1, FrameTicks - 1);
  endtask
`endif

  initial begin
    bus.rdy_clr = 1'b0;
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_clr_collision();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #5ms;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
